fetch_queue: RTL and testbench

Instruction prefetch buffer between the fetch stage and decode. It captures each `{PC, instruction}` pair produced by fetch and instruction memory in a small circular FIFO, and presents the pairs to decode over a valid/ready handshake. It back-pressures fetch when full and discards all buffered instructions on a taken branch. It decouples PC advance from decode stalls without changing program order.

---
 rtl/fetch_queue_pkg.sv | 24 ++
 rtl/fetch_queue_mem.sv | 38 +++
 rtl/fetch_queue.sv | 129 ++++++++++++
 tb/tb_fetch_queue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Package : fetchq_pkg
// Brief   : Shared constants and entry type for the fetch_queue prefetch
//           buffer (entry layout, default depth, empty output word).
// Rev     : 1.0 - initial release
// ============================================================================
package fetchq_pkg;

    localparam int FQ_N                 = 64;
    localparam int FQ_IW                = 32;
    localparam int FETCHQ_DEPTH_DEFAULT = 4;

    // One buffered fetch result: PC in the upper bits, instruction below.
    typedef struct packed {
        logic [FQ_N-1:0]  pc;
        logic [FQ_IW-1:0] instr;
    } fetchq_entry_t;

    // Value driven on the decode-side data outputs while nothing is valid.
    localparam fetchq_entry_t FETCHQ_EMPTY_WORD = '0;

endpackage : fetchq_pkg
`default_nettype wire

// File: rtl/fetch_queue_mem.sv
`default_nettype none
// ============================================================================
// Module  : fetchq_mem
// Brief   : DEPTH x W register array, one synchronous write port and one
//           asynchronous read port. The array is deliberately not reset.
// Rev     : 1.0 - initial release
// ============================================================================
module fetchq_mem
    import fetchq_pkg::*;
#(
    parameter int W     = FQ_N + FQ_IW,
    parameter int DEPTH = FETCHQ_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // Storage write; contents survive reset and flush by design.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Asynchronous read of the addressed entry.
    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule : fetchq_mem
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : fetch_queue
// Brief   : Circular {PC, instruction} prefetch FIFO between fetch and decode
//           with valid/ready handshake, back-pressure and branch flush.
//           Optional macro FETCHQ_BYPASS_EN: when the queue is empty the
//           incoming pair is forwarded to decode in the same cycle.
// Rev     : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetchq_pkg::*;
#(
    parameter int N     = FQ_N,
    parameter int IW    = FQ_IW,
    parameter int DEPTH = FETCHQ_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_F,
    input  logic                       in_valid,
    input  logic [N-1:0]               in_pc,
    input  logic [IW-1:0]              in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [N-1:0]               out_pc,
    output logic [IW-1:0]              out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int             AW   = $clog2(DEPTH);
    localparam int             CW   = $clog2(DEPTH+1);
    localparam int             W    = N + IW;
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;

    logic          not_empty;
    logic          bypass_take;
    logic          enq;
    logic          deq;
    logic [W-1:0]  rdata;

    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q != FULL);
    assign count     = count_q;

`ifdef FETCHQ_BYPASS_EN
    // Empty queue with a live input: decode sees it now; if taken it never lands in storage.
    logic bypass;
    assign bypass      = ~not_empty & in_valid & ~flush_F;
    assign bypass_take = bypass & out_ready;
`else
    assign bypass_take = 1'b0;
`endif

    assign enq = in_valid & in_ready & ~flush_F & ~bypass_take;
    assign deq = not_empty & out_ready & ~flush_F;

    fetchq_mem #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (enq),
        .waddr (wp_q),
        .wdata ({in_pc, in_instr}),
        .raddr (rp_q),
        .rdata (rdata)
    );

    // Next pointers and occupancy; flush discards everything and wins over enq/deq.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (flush_F) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                wp_d = wp_q + AW'(1);
            end
            if (deq) begin
                rp_d = rp_q + AW'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Decode-side outputs: head entry when valid, zeros otherwise (or the bypassed input).
    always_comb begin
        out_valid            = not_empty;
        {out_pc, out_instr}  = W'(FETCHQ_EMPTY_WORD);
        if (not_empty) begin
            {out_pc, out_instr} = rdata;
        end
`ifdef FETCHQ_BYPASS_EN
        if (bypass) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_instr = in_instr;
        end
`endif
    end

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_queue
// Brief   : Self-checking bench for fetch_queue (DEPTH=4): table of directed
//           vectors plus hand-written async-reset and bypass sequences.
//           Honours FETCHQ_BYPASS_EN when it is defined for the build.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;
    import fetchq_pkg::*;

    logic        clk;
    logic        reset;
    logic        flush_F;
    logic        in_valid;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [2:0]  count;

    int tests;
    int fails;

    fetch_queue #(.N(64), .IW(32), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush_F   (flush_F),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied this cycle, and the outputs expected before the edge.
    typedef struct {
        logic        flush;
        logic        iv;
        logic [63:0] ipc;
        logic [31:0] iin;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [2:0]  e_cnt;
        logic [63:0] e_pc;
        logic [31:0] e_in;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic fl, input logic iv, input logic [63:0] ipc,
                                input logic ordy, input logic ov, input logic ir,
                                input logic [2:0] cnt, input logic [63:0] hpc);
        vec_t v;
        v.flush = fl;
        v.iv    = iv;
        v.ipc   = ipc;
        v.iin   = 32'hA0 + 32'(ipc >> 2);
        v.ordy  = ordy;
        v.e_ov  = ov;
        v.e_ir  = ir;
        v.e_cnt = cnt;
        v.e_pc  = ov ? hpc : 64'h0;
        v.e_in  = ov ? 32'hA0 + 32'(hpc >> 2) : 32'h0;
        vq.push_back(v);
    endfunction

    task automatic drive_idle();
        flush_F   = 1'b0;
        in_valid  = 1'b0;
        in_pc     = 64'h0;
        in_instr  = 32'h0;
        out_ready = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        drive_idle();

        //   flush iv  in_pc   ordy | ov ir cnt head_pc
        add(0, 0, 64'h00, 1,   0, 1, 3'd0, 64'h00);  // idle, out_ready ignored
        add(0, 0, 64'h00, 0,   0, 1, 3'd0, 64'h00);
        add(0, 1, 64'h00, 0,   0, 1, 3'd0, 64'h00);  // fill
        add(0, 1, 64'h04, 0,   1, 1, 3'd1, 64'h00);
        add(0, 1, 64'h08, 0,   1, 1, 3'd2, 64'h00);
        add(0, 1, 64'h0C, 0,   1, 1, 3'd3, 64'h00);
        add(0, 1, 64'h10, 0,   1, 0, 3'd4, 64'h00);  // full: 0x10 refused
        add(0, 1, 64'h10, 1,   1, 0, 3'd4, 64'h00);  // dequeue only
        add(0, 1, 64'h10, 1,   1, 1, 3'd3, 64'h04);  // steady stream, wraps
        add(0, 1, 64'h14, 1,   1, 1, 3'd3, 64'h08);
        add(0, 1, 64'h18, 1,   1, 1, 3'd3, 64'h0C);
        add(0, 1, 64'h1C, 1,   1, 1, 3'd3, 64'h10);
        add(0, 1, 64'h20, 1,   1, 1, 3'd3, 64'h14);
        add(0, 1, 64'h24, 1,   1, 1, 3'd3, 64'h18);
        add(0, 1, 64'h28, 1,   1, 1, 3'd3, 64'h1C);
        add(1, 1, 64'h2C, 1,   1, 1, 3'd3, 64'h20);  // flush with enq+deq
        add(0, 0, 64'h00, 1,   0, 1, 3'd0, 64'h00);
        add(0, 1, 64'h30, 0,   0, 1, 3'd0, 64'h00);
        add(0, 0, 64'h00, 0,   1, 1, 3'd1, 64'h30);  // 0x2C must not appear
        add(0, 0, 64'h00, 1,   1, 1, 3'd1, 64'h30);
        add(0, 0, 64'h00, 0,   0, 1, 3'd0, 64'h00);

        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            v = vq[i];
`ifdef FETCHQ_BYPASS_EN
            if (v.e_cnt == 3'd0 && v.iv && !v.flush) begin
                v.e_ov = 1'b1;
                v.e_pc = v.ipc;
                v.e_in = v.iin;
            end
`endif
            flush_F   = v.flush;
            in_valid  = v.iv;
            in_pc     = v.ipc;
            in_instr  = v.iin;
            out_ready = v.ordy;
            #1;
            chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(v.e_ov));
            chk($sformatf("v%0d in_ready", i),  64'(in_ready),  64'(v.e_ir));
            chk($sformatf("v%0d count", i),     64'(count),     64'(v.e_cnt));
            chk($sformatf("v%0d out_pc", i),    out_pc,         v.e_pc);
            chk($sformatf("v%0d out_instr", i), 64'(out_instr), 64'(v.e_in));
            @(posedge clk);
            #1;
        end
        drive_idle();

        // Asynchronous reset mid-cycle with two entries held.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_pc    = 64'h100 + 64'(i * 4);
            in_instr = 32'hC0 + 32'(i);
            @(posedge clk);
            #1;
        end
        drive_idle();
        #1;
        chk("pre-reset count", 64'(count), 64'd2);
        chk("pre-reset out_pc", out_pc, 64'h100);
        #1 reset = 1'b1;
        #1;
        chk("async reset count", 64'(count), 64'd0);
        chk("async reset out_valid", 64'(out_valid), 64'd0);
        chk("async reset in_ready", 64'(in_ready), 64'd1);
        chk("async reset out_pc", out_pc, 64'h0);
        chk("async reset out_instr", 64'(out_instr), 64'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Empty queue, incoming pair with decode ready.
        in_valid  = 1'b1;
        in_pc     = 64'h40;
        in_instr  = 32'hB0;
        out_ready = 1'b1;
        #1;
`ifdef FETCHQ_BYPASS_EN
        chk("bypass same-cycle out_valid", 64'(out_valid), 64'd1);
        chk("bypass same-cycle out_pc", out_pc, 64'h40);
        chk("bypass same-cycle out_instr", 64'(out_instr), 64'hB0);
`else
        chk("no-bypass same-cycle out_valid", 64'(out_valid), 64'd0);
        chk("no-bypass same-cycle out_pc", out_pc, 64'h0);
`endif
        @(posedge clk);
        #1;
        drive_idle();
        #1;
`ifdef FETCHQ_BYPASS_EN
        chk("bypass post-edge count", 64'(count), 64'd0);
        chk("bypass post-edge out_valid", 64'(out_valid), 64'd0);
`else
        chk("no-bypass post-edge count", 64'(count), 64'd1);
        chk("no-bypass post-edge out_valid", 64'(out_valid), 64'd1);
        chk("no-bypass post-edge out_pc", out_pc, 64'h40);
        chk("no-bypass post-edge out_instr", 64'(out_instr), 64'hB0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_fetch_queue
`default_nettype wire
